// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: post-reset fetch hold, load-use bubbles, taken-branch flushes,
// memory-busy freezes with a watchdog halt, and a saturating stall-cycle counter.
// Optional define BRANCH_DELAY_SLOT_EN lets the delay-slot instruction in ID proceed on a taken branch.
module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  i_ID_rs,
  input  logic [4:0]  i_ID_rt,
  input  logic        i_ID_useRs,
  input  logic        i_ID_useRt,
  input  logic [4:0]  i_EX_rd,
  input  logic        i_EX_memRead,
  input  logic        i_EX_regWrite,
  input  logic        i_EX_branchTaken,
  input  logic        i_MEM_busy,
  output logic        o_IF_PCWrite,
  output logic        o_IFID_write,
  output logic        o_IDEX_write,
  output logic        o_EXMEM_write,
  output logic        o_IFID_flush,
  output logic        o_IDEX_flush,
  output logic        o_MEMWB_flush,
  output logic        o_halt,
  output logic [15:0] o_stallCount,
  output logic [1:0]  o_dbg_state
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = ($clog2(MEM_TIMEOUT + 1) > 7) ? $clog2(MEM_TIMEOUT + 1) : 7;

  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic BR_IDEX_FLUSH = 1'b0;
`else
  localparam logic BR_IDEX_FLUSH = 1'b1;
`endif

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic [15:0]   stall_q, stall_d;
  logic          load_use;
  logic          run_rules;

  assign load_use = i_EX_memRead & i_EX_regWrite & (i_EX_rd != 5'd0) &
                    ((i_ID_useRs & (i_ID_rs == i_EX_rd)) |
                     (i_ID_useRt & (i_ID_rt == i_EX_rd)));
  assign wait_inc = wait_cnt_q + WW'(1);
  // RUN and the exit cycle of MEM_WAIT share the branch / load-use rules.
  assign run_rules = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !i_MEM_busy;

  always_comb begin
    o_IF_PCWrite  = 1'b1;
    o_IFID_write  = 1'b1;
    o_IDEX_write  = 1'b1;
    o_EXMEM_write = 1'b1;
    o_IFID_flush  = 1'b0;
    o_IDEX_flush  = 1'b0;
    o_MEMWB_flush = 1'b0;
    o_halt        = 1'b0;
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      S_INIT: begin
        o_IF_PCWrite = 1'b0;
        o_IFID_flush = 1'b1;
        o_IDEX_flush = 1'b1;
        if (init_cnt_q == '0) state_d = S_RUN;
        else                  init_cnt_d = init_cnt_q - IW'(1);
      end
      S_RUN: begin
        if (i_MEM_busy) begin
          wait_cnt_d = WW'(1);
          state_d    = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (i_MEM_busy) begin
          wait_cnt_d = wait_inc;
          // wait_inc counts busy cycles including the current one.
          if (wait_inc == WW'(MEM_TIMEOUT)) state_d = S_HALT;
        end else begin
          wait_cnt_d = '0;
          state_d    = S_RUN;
        end
      end
      S_HALT: begin
        o_halt = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    if ((state_q == S_HALT) ||
        (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && i_MEM_busy)) begin
      o_IF_PCWrite  = 1'b0;
      o_IFID_write  = 1'b0;
      o_IDEX_write  = 1'b0;
      o_EXMEM_write = 1'b0;
      o_MEMWB_flush = 1'b1;
    end else if (run_rules) begin
      if (i_EX_branchTaken) begin
        o_IFID_flush = 1'b1;
        o_IDEX_flush = BR_IDEX_FLUSH;
      end else if (load_use) begin
        o_IF_PCWrite = 1'b0;
        o_IFID_write = 1'b0;
        o_IDEX_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !o_IF_PCWrite &&
        (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_INIT;
      init_cnt_q <= IW'(INIT_CYCLES - 1);
      wait_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign o_stallCount = stall_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle hazard responses,
// hand-written sequences for init, freeze, watchdog halt, reset and counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int INIT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 4;

  // Packed outputs: {PCWrite, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write, MEMWB_flush, halt}
  localparam logic [7:0] OUT_RESET  = 8'b0111_1100;
  localparam logic [7:0] OUT_NORMAL = 8'b1101_0100;
  localparam logic [7:0] OUT_STALL  = 8'b0001_1100;
  localparam logic [7:0] OUT_FREEZE = 8'b0000_0010;
  localparam logic [7:0] OUT_HALT   = 8'b0000_0011;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic [7:0] OUT_BRANCH = 8'b1111_0100;
`else
  localparam logic [7:0] OUT_BRANCH = 8'b1111_1100;
`endif

  logic        clk, nrst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        use_rs, use_rt, mem_rd, reg_wr, br_taken, mem_busy;
  logic        pcw, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, halt;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .nrst(nrst),
    .i_ID_rs(id_rs), .i_ID_rt(id_rt), .i_ID_useRs(use_rs), .i_ID_useRt(use_rt),
    .i_EX_rd(ex_rd), .i_EX_memRead(mem_rd), .i_EX_regWrite(reg_wr),
    .i_EX_branchTaken(br_taken), .i_MEM_busy(mem_busy),
    .o_IF_PCWrite(pcw), .o_IFID_write(ifid_w), .o_IDEX_write(idex_w),
    .o_EXMEM_write(exmem_w), .o_IFID_flush(ifid_f), .o_IDEX_flush(idex_f),
    .o_MEMWB_flush(memwb_f), .o_halt(halt), .o_stallCount(stall_cnt),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, mrd, rwr, br;
    logic [7:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_sc = 0;

  function automatic logic [7:0] outs();
    return {pcw, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, halt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, rt, rd, input logic urs, urt, mrd, rwr, br, busy);
    id_rs = rs; id_rt = rt; ex_rd = rd;
    use_rs = urs; use_rt = urt; mem_rd = mrd; reg_wr = rwr;
    br_taken = br; mem_busy = busy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_run();
    @(negedge clk) nrst = 1'b1;
    #1;
    chk("init_c0_outs", outs(), OUT_RESET);
    step();
    chk("init_c1_outs", outs(), OUT_RESET);
    step();
    chk("init_c2_outs", outs(), OUT_NORMAL);
    chk("init_c2_state", dbg_state, 2'd1);
    chk("init_stall", stall_cnt, 0);
  endtask

  initial begin
    //            name             rs     rt     rd    urs   urt   mrd   rwr   br    expected
    vecs.push_back('{"plain",      5'd1,  5'd2,  5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, OUT_NORMAL});
    vecs.push_back('{"lu_rt",      5'd1,  5'd5,  5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, OUT_STALL});
    vecs.push_back('{"lu_rd0",     5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, OUT_NORMAL});
    vecs.push_back('{"lu_rs",      5'd7,  5'd2,  5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, OUT_STALL});
    vecs.push_back('{"rs_unused",  5'd7,  5'd2,  5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, OUT_NORMAL});
    vecs.push_back('{"rt_unused",  5'd3,  5'd9,  5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, OUT_NORMAL});
    vecs.push_back('{"no_load",    5'd4,  5'd4,  5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, OUT_NORMAL});
    vecs.push_back('{"no_regwr",   5'd4,  5'd4,  5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, OUT_NORMAL});
    vecs.push_back('{"branch",     5'd1,  5'd2,  5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, OUT_BRANCH});
    vecs.push_back('{"br_and_lu",  5'd6,  5'd6,  5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, OUT_BRANCH});
    vecs.push_back('{"lu_both",    5'd31, 5'd31, 5'd31,1'b1, 1'b1, 1'b1, 1'b1, 1'b0, OUT_STALL});

    nrst = 1'b0;
    idle();
    #2;
    chk("reset_outs", outs(), OUT_RESET);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_state", dbg_state, 2'd0);
    wait_run();

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].urs, vecs[i].urt,
            vecs[i].mrd, vecs[i].rwr, vecs[i].br, 1'b0);
      exp_q.push_back(vecs[i].exp);
      #1;
      chk({"vec_", vecs[i].name}, outs(), exp_q.pop_front());
      if (!vecs[i].exp[7]) exp_sc++;
      step();
      chk({"vec_stall_", vecs[i].name}, stall_cnt, exp_sc);
    end

    // Three busy cycles, exit with a taken branch still held in EX
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_outs", outs(), OUT_FREEZE);
      step();
    end
    chk("busy_state", dbg_state, 2'd2);
    mem_busy = 1'b0;
    br_taken = 1'b1;
    #1;
    chk("busy_exit_branch", outs(), OUT_BRANCH);
    exp_sc += 3;
    step();
    chk("busy_stall", stall_cnt, exp_sc);
    chk("busy_exit_state", dbg_state, 2'd1);
    idle();

    // Watchdog: busy held for MEM_TIMEOUT cycles
    mem_busy = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      chk("wd_freeze", outs(), OUT_FREEZE);
      step();
    end
    chk("wd_halt", outs(), OUT_HALT);
    mem_busy = 1'b0;
    #1;
    chk("wd_halt_idle", outs(), OUT_HALT);
    step();
    chk("wd_halt_hold", outs(), OUT_HALT);
    exp_sc += MEM_TIMEOUT;
    chk("wd_stall", stall_cnt, exp_sc);
    nrst = 1'b0;
    #1;
    chk("halt_reset_outs", outs(), OUT_RESET);
    chk("halt_reset_stall", stall_cnt, 0);
    chk("halt_reset_state", dbg_state, 2'd0);
    wait_run();

    // Saturation under a held load-use hazard
    drive(5'd0, 5'd12, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sat_outs", outs(), OUT_STALL);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_value", stall_cnt, 16'hFFFF);
    step();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    nrst = 1'b0;
    #1;
    chk("stall_reset_cnt", stall_cnt, 0);
    chk("stall_reset_outs", outs(), OUT_RESET);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
